// File: rtl/table_reader_if.sv
// Table responder bus: one-hot address and enable out, registered byte back.
// The responder returns data one cycle after rom_en/rom_addr are presented.
interface table_reader_if;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/table_reader.sv
// Walking-one table scan accumulating XOR, sum and non-zero count of the returned bytes.
// Optional per-entry capture buffer is built when TABLE_READER_CAPTURE_EN is defined.
module table_reader #(
  parameter int N_ENTRIES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  table_reader_if.master bus,
  output logic [7:0]     xor_sum,
  output logic [10:0]    add_sum,
  output logic [3:0]     nz_cnt,
  input  logic [2:0]     rd_idx,
  output logic [7:0]     rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(N_ENTRIES - 1);

  state_t     state;
  logic [2:0] idx;
  logic       rom_en_q;
  logic [7:0] rom_addr_q;
  logic       vld_p1;
  logic       start_acc;

  function automatic logic [10:0] add_byte(input logic [10:0] acc, input logic [7:0] d);
    return acc + {3'b000, d};
  endfunction

  function automatic logic [3:0] count_nz(input logic [3:0] cnt, input logic [7:0] d);
    return cnt + {3'b000, |d};
  endfunction

  // A new scan may only begin from IDLE or from the single DONE cycle.
  assign start_acc    = start && (state == IDLE || state == DONE);
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      vld_p1     <= 1'b0;
      xor_sum    <= '0;
      add_sum    <= '0;
      nz_cnt     <= '0;
    end else begin
      done   <= 1'b0;
      // Stage p1: byte returned for the previous ISSUE cycle is accumulated.
      vld_p1 <= rom_en_q;
      if (vld_p1) begin
        xor_sum <= xor_sum ^ bus.rom_data;
        add_sum <= add_byte(add_sum, bus.rom_data);
        nz_cnt  <= count_nz(nz_cnt, bus.rom_data);
      end
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start_acc) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            idx        <= '0;
            rom_en_q   <= 1'b1;
            rom_addr_q <= 8'h01;
            xor_sum    <= '0;
            add_sum    <= '0;
            nz_cnt     <= '0;
          end
        end
        ISSUE: begin
          if (idx == LAST_IDX) begin
            state      <= DRAIN;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
          end else begin
            idx        <= idx + 3'd1;
            rom_addr_q <= rom_addr_q << 1;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TABLE_READER_CAPTURE_EN
  logic [7:0] cap_mem [8];
  logic [2:0] wr_idx_p1;

  // Writes track the accumulator stage, so slot k holds the k-th returned byte.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      for (int k = 0; k < 8; k++) cap_mem[k] <= '0;
      wr_idx_p1 <= '0;
    end else if (vld_p1) begin
      cap_mem[wr_idx_p1] <= bus.rom_data;
      wr_idx_p1          <= wr_idx_p1 + 3'd1;
    end
  end

  assign rd_data = cap_mem[rd_idx];
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_data       = 8'h00;
`endif

endmodule

// File: doc/table_reader.md
TABLE_READER -- requirements
Module: table_reader

Interface
REQ-001 SHALL have parameter: N_ENTRIES, 8, number of walking-one addresses scanned (legal 1..8).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  scan request, sampled each cycle.
REQ-005 SHALL have port: busy  output  1  high from start acceptance through the DRAIN state.
REQ-006 SHALL have port: done  output  1  one-cycle pulse, results valid.
REQ-007 SHALL have port: rom_en  output  1  enable to table responder.
REQ-008 SHALL have port: rom_addr  output  8  one-hot address to responder.
REQ-009 SHALL have port: rom_data  input  8  responder data, registered, valid 1 cycle after rom_en/rom_addr.
REQ-010 SHALL have port: xor_sum  output  8  XOR of all returned bytes.
REQ-011 SHALL have port: add_sum  output  11  unsigned sum of all returned bytes.
REQ-012 SHALL have port: nz_cnt  output  4  count of returned bytes not equal to 0x00.
REQ-013 SHALL have port: rd_idx  input  3  capture-buffer read index.
REQ-014 SHALL have port: rd_data  output  8  capture-buffer read data, combinational from rd_idx.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 -> ISSUE; clear xor_sum, add_sum, nz_cnt and index to 0.
REQ-017 ISSUE: rom_en=1, rom_addr=1<<idx; idx increments each cycle; after idx=N_ENTRIES-1 -> DRAIN.
REQ-018 Outside ISSUE, rom_en SHALL be 0 and rom_addr SHALL be 0x00.
REQ-019 In every cycle following an ISSUE cycle, SHALL capture rom_data: xor_sum^=data, add_sum+=data (zero-extended, no wrap for N<=8), nz_cnt+=(data!=0).
REQ-020 DRAIN: capture final byte -> DONE; lasts exactly one cycle.
REQ-021 DONE: done=1 for exactly one cycle, busy=0; -> IDLE, or -> ISSUE with accumulators cleared if start=1 (back-to-back).
REQ-022 start SHALL be ignored in ISSUE and DRAIN; no restart, no effect on results.
REQ-023 Latency: start accepted at cycle T -> ISSUE T+1..T+N, DRAIN T+N+1, done at T+N+2.
REQ-024 xor_sum, add_sum, nz_cnt SHALL hold their final values after DONE until the next accepted start.

Reset
REQ-025 rst=1 SHALL force IDLE at next edge, regardless of state, including mid-scan.
REQ-026 Reset values: busy=0, done=0, rom_en=0, rom_addr=0x00, xor_sum=0x00, add_sum=0, nz_cnt=0, idx=0, capture buffer all 0x00.
REQ-027 A scan aborted by reset SHALL produce no done pulse; partial results discarded.

Configuration
REQ-028 Macro TABLE_READER_CAPTURE_EN defined: each captured byte k SHALL be stored in an 8x8 buffer at index k; rd_data=buffer[rd_idx]; entries >= N_ENTRIES read 0x00; buffer cleared on accepted start.
REQ-029 Macro undefined: no buffer SHALL be built; rd_data SHALL be constant 0x00; ports unchanged.

Verification (bench responder model: 01->33, 02->CC, 04->0F, 08->F0, 10->FF, 20->28, 40->02, 80->AA, else 00; registered, zero when en=0)
REQ-030 Reset then start pulse, N=8 -> rom_addr 01,02,...,80 on 8 consecutive cycles; done at T+10; xor_sum=0x7F, add_sum=0x3D1, nz_cnt=8.
REQ-031 With TABLE_READER_CAPTURE_EN, after REQ-030 scan: rd_idx=0..7 -> 33,CC,0F,F0,FF,28,02,AA; without macro -> all 00.
REQ-032 N_ENTRIES=3, start -> addresses 01,02,04; done at T+5; xor_sum=0xF0, add_sum=0x10E, nz_cnt=3.
REQ-033 rst asserted during 4th ISSUE cycle -> next cycle rom_en=0, busy=0, all results 0, no done pulse; new start then yields REQ-030 values.
REQ-034 start held high continuously -> start during ISSUE/DRAIN ignored; back-to-back scans, done every 10 cycles, identical results each scan.
